mmio_bridge: RTL and testbench

Memory-mapped I/O bridge between the CPU memory port and the 256-word RAM on the lab board. It decodes every CPU access by address, steers RAM traffic to RAM and I/O traffic to a small register bank (LEDs, 7-segment value, switch input, cycle timer), and returns read data with a uniform one-cycle latency. It also provides the registered LED outputs, the HEX display value and the switch inputs used at top level.

---
 rtl/mmio_bridge.sv | 180 ++++++++++++++++++
 tb/tb_mmio_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes CPU accesses into the 256-word RAM and a small I/O register bank.
// The cycle timer at TMR_ADDR is built only when MMIO_TIMER_EN is defined.
module mmio_bridge #(
    parameter logic [8:0] LED_ADDR = 9'h100,
    parameter logic [8:0] HEX_ADDR = 9'h120,
    parameter logic [8:0] SW_ADDR  = 9'h140,
    parameter logic [8:0] TMR_ADDR = 9'h180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_write,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  sw_in,
    input  logic        halt,
    output logic [7:0]  led_out,
    output logic [15:0] hex_value,
    output logic        bad_access
);
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'b00,
        SEL_RAM  = 2'b01,
        SEL_IO   = 2'b10
    } rd_sel_t;

    logic        is_read_s, is_write_s, is_io_s;
    logic        hit_led_s, hit_hex_s, hit_sw_s, hit_tmr_s;
    logic        io_rd_ok_s, io_wr_ok_s, illegal_s;
    logic [15:0] io_word_s;
    logic [15:0] timer_s;
    rd_sel_t     rd_sel_r, rd_sel_next_s;
    logic [15:0] io_q_r, io_q_next_s;
    logic [7:0]  sw_meta_r, sw_sync_r;
    logic [7:0]  led_r;
    logic [15:0] hex_r;
    logic        bad_r;

    assign is_read_s  = (mem_cmd == CMD_READ);
    assign is_write_s = (mem_cmd == CMD_WRITE);
    assign is_io_s    = mem_addr[8];
    assign hit_led_s  = (mem_addr == LED_ADDR);
    assign hit_hex_s  = (mem_addr == HEX_ADDR);
    assign hit_sw_s   = (mem_addr == SW_ADDR);

    assign ram_addr   = mem_addr[7:0];
    assign ram_din    = write_data;
    assign ram_write  = is_write_s & ~is_io_s;

`ifdef MMIO_TIMER_EN
    logic [15:0] timer_r;

    assign hit_tmr_s = (mem_addr == TMR_ADDR);
    assign timer_s   = timer_r;

    // Free-running cycle timer; a CPU store overrides the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= 16'h0000;
        end else if (is_write_s && hit_tmr_s) begin
            timer_r <= write_data;
        end else if (!halt) begin
            timer_r <= timer_r + 16'h0001;
        end else begin
            timer_r <= timer_r;
        end
    end
`else
    logic halt_unused_s;

    assign halt_unused_s = halt;
    assign hit_tmr_s     = 1'b0;
    assign timer_s       = 16'h0000;
`endif

    // I/O read mux; anything without a readable register reports not-ok.
    always_comb begin
        io_word_s  = 16'h0000;
        io_rd_ok_s = 1'b0;
        if (hit_led_s) begin
            io_word_s  = {8'h00, led_r};
            io_rd_ok_s = 1'b1;
        end else if (hit_hex_s) begin
            io_word_s  = hex_r;
            io_rd_ok_s = 1'b1;
        end else if (hit_sw_s) begin
            io_word_s  = {8'h00, sw_sync_r};
            io_rd_ok_s = 1'b1;
        end else if (hit_tmr_s) begin
            io_word_s  = timer_s;
            io_rd_ok_s = 1'b1;
        end else begin
            io_word_s  = 16'h0000;
            io_rd_ok_s = 1'b0;
        end
    end

    assign io_wr_ok_s = hit_led_s | hit_hex_s | hit_tmr_s;
    assign illegal_s  = is_io_s & ((is_read_s & ~io_rd_ok_s) | (is_write_s & ~io_wr_ok_s));

    // Read-source selection; held between reads so read_data stays stable.
    always_comb begin
        rd_sel_next_s = rd_sel_r;
        io_q_next_s   = io_q_r;
        if (is_read_s) begin
            if (!is_io_s) begin
                rd_sel_next_s = SEL_RAM;
            end else if (io_rd_ok_s) begin
                rd_sel_next_s = SEL_IO;
                io_q_next_s   = io_word_s;
            end else begin
                rd_sel_next_s = SEL_ZERO;
            end
        end else begin
            rd_sel_next_s = rd_sel_r;
            io_q_next_s   = io_q_r;
        end
    end

    // Read-path state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_r <= SEL_ZERO;
            io_q_r   <= 16'h0000;
        end else begin
            rd_sel_r <= rd_sel_next_s;
            io_q_r   <= io_q_next_s;
        end
    end

    // Final load-data mux; RAM data arrives one cycle after its address.
    always_comb begin
        case (rd_sel_r)
            SEL_RAM: read_data = ram_dout;
            SEL_IO:  read_data = io_q_r;
            default: read_data = 16'h0000;
        endcase
    end

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_r <= 8'h00;
            sw_sync_r <= 8'h00;
        end else begin
            sw_meta_r <= sw_in;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Writable I/O registers and the sticky illegal-access flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 8'h00;
            hex_r <= 16'h0000;
            bad_r <= 1'b0;
        end else begin
            if (is_write_s && hit_led_s) begin
                led_r <= write_data[7:0];
            end
            if (is_write_s && hit_hex_s) begin
                hex_r <= write_data;
            end
            if (illegal_s) begin
                bad_r <= 1'b1;
            end
        end
    end

    assign led_out    = led_r;
    assign hex_value  = hex_r;
    assign bad_access = bad_r;
endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed test-plan scenarios plus randomized traffic
// checked against a transaction-level model of the memory map.
module tb_mmio_bridge;
    localparam logic [8:0] LED_A = 9'h100;
    localparam logic [8:0] HEX_A = 9'h120;
    localparam logic [8:0] SW_A  = 9'h140;
    localparam logic [8:0] TMR_A = 9'h180;
    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mem_cmd = 2'b00;
    logic [8:0]  mem_addr = 9'h000;
    logic [15:0] write_data = 16'h0000;
    logic [15:0] read_data;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_write;
    logic [15:0] ram_dout;
    logic [7:0]  sw_in = 8'h00;
    logic        halt = 1'b0;
    logic [7:0]  led_out;
    logic [15:0] hex_value;
    logic        bad_access;

    int checks = 0;
    int errors = 0;

    // Board RAM: synchronous read, one-cycle latency.
    logic [15:0] ram_mem [0:255] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    always #5 clk = ~clk;

    mmio_bridge dut (
        .clk(clk), .rst_n(rst_n), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_write(ram_write), .ram_dout(ram_dout),
        .sw_in(sw_in), .halt(halt), .led_out(led_out), .hex_value(hex_value),
        .bad_access(bad_access)
    );

    // Reference model state
    logic [15:0] ref_ram [0:255] = '{default: 16'h0000};
    logic [7:0]  ref_led;
    logic [15:0] ref_hex;
    logic        ref_bad;
    logic [15:0] ref_rd;
    logic        hold_ok;
    logic [7:0]  sw_p1, sw_p2;
`ifdef MMIO_TIMER_EN
    logic [15:0] ref_timer;
`endif
    logic [7:0]  sw_drive = 8'h00;
    logic        halt_drive = 1'b0;

    task automatic model_reset();
        ref_led = 8'h00;
        ref_hex = 16'h0000;
        ref_bad = 1'b0;
        ref_rd  = 16'h0000;
        hold_ok = 1'b1;
        sw_p1   = 8'h00;
        sw_p2   = 8'h00;
`ifdef MMIO_TIMER_EN
        ref_timer = 16'h0000;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        mem_cmd = C_NONE;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, then registered ones after the edge.
    task automatic step(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
        logic rd, wr, io;
        logic [15:0] rv;
        @(negedge clk);
        mem_cmd = cmd; mem_addr = addr; write_data = wd; sw_in = sw_drive; halt = halt_drive;
        #1;
        rd = (cmd == C_READ);
        wr = (cmd == C_WRITE);
        io = addr[8];
        checks++;
        if (ram_write !== (wr && !io)) begin
            errors++;
            $display("FAIL ram_write addr=%h cmd=%b got %b want %b", addr, cmd, ram_write, wr && !io);
        end
        checks++;
        if (ram_addr !== addr[7:0] || ram_din !== wd) begin
            errors++;
            $display("FAIL ram_port got addr=%h din=%h want addr=%h din=%h", ram_addr, ram_din, addr[7:0], wd);
        end
        rv = 16'h0000;
        if (rd) begin
            if (!io) rv = ref_ram[addr[7:0]];
            else if (addr == LED_A) rv = {8'h00, ref_led};
            else if (addr == HEX_A) rv = ref_hex;
            else if (addr == SW_A) rv = {8'h00, sw_p2};
`ifdef MMIO_TIMER_EN
            else if (addr == TMR_A) rv = ref_timer;
`endif
            else ref_bad = 1'b1;
            ref_rd  = rv;
            hold_ok = io;
        end
        if (wr) begin
            if (!io) ref_ram[addr[7:0]] = wd;
            else if (addr == LED_A) ref_led = wd[7:0];
            else if (addr == HEX_A) ref_hex = wd;
`ifdef MMIO_TIMER_EN
            else if (addr == TMR_A) begin end
`endif
            else ref_bad = 1'b1;
        end
`ifdef MMIO_TIMER_EN
        if (wr && addr == TMR_A) ref_timer = wd;
        else if (!halt_drive) ref_timer = ref_timer + 16'd1;
`endif
        sw_p2 = sw_p1;
        sw_p1 = sw_drive;
        @(posedge clk);
        #1;
        checks++;
        if (led_out !== ref_led) begin
            errors++;
            $display("FAIL led_out got %h want %h", led_out, ref_led);
        end
        checks++;
        if (hex_value !== ref_hex) begin
            errors++;
            $display("FAIL hex_value got %h want %h", hex_value, ref_hex);
        end
        checks++;
        if (bad_access !== ref_bad) begin
            errors++;
            $display("FAIL bad_access got %b want %b", bad_access, ref_bad);
        end
        if (rd || hold_ok) begin
            checks++;
            if (read_data !== ref_rd) begin
                errors++;
                $display("FAIL read_data addr=%h got %h want %h", addr, read_data, ref_rd);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        step(C_WRITE, LED_A, 16'h00C3);
        step(C_WRITE, HEX_A, 16'h1234);
        step(C_READ, HEX_A, 16'h0000);
        @(negedge clk);
        mem_cmd = C_WRITE; mem_addr = LED_A; write_data = 16'h005A;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led_out !== 8'h00 || hex_value !== 16'h0000 || read_data !== 16'h0000 || bad_access !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got led=%h hex=%h rd=%h bad=%b want all zero",
                     led_out, hex_value, read_data, bad_access);
        end
        @(posedge clk);
        #1;
        mem_cmd = C_NONE;
        rst_n = 1'b1;
        model_reset();
        step(C_NONE, 9'h000, 16'h0000);
        checks++;
        if (led_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_led_update got %h want 00", led_out);
        end
    endtask

    task automatic test_ram();
        step(C_WRITE, 9'h014, 16'h0352);
        step(C_READ, 9'h014, 16'h0000);
        checks++;
        if (read_data !== 16'h0352) begin
            errors++;
            $display("FAIL ram_readback got %h want 0352", read_data);
        end
    endtask

    task automatic test_io();
        step(C_WRITE, LED_A, 16'h00A5);
        step(C_WRITE, HEX_A, 16'hBEEF);
        step(C_READ, HEX_A, 16'h0000);
        checks++;
        if (led_out !== 8'hA5 || hex_value !== 16'hBEEF || read_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL io_regs got led=%h hex=%h rd=%h want A5 BEEF BEEF", led_out, hex_value, read_data);
        end
        step(C_READ, LED_A, 16'h0000);
    endtask

    task automatic test_switch();
        sw_drive = 8'h3C;
        step(C_NONE, 9'h000, 16'h0000);
        step(C_READ, SW_A, 16'h0000);
        checks++;
        if (read_data !== 16'h0000) begin
            errors++;
            $display("FAIL sw_early got %h want 0000", read_data);
        end
        step(C_READ, SW_A, 16'h0000);
        checks++;
        if (read_data !== 16'h003C) begin
            errors++;
            $display("FAIL sw_sync got %h want 003C", read_data);
        end
    endtask

    task automatic test_illegal();
        step(C_READ, HEX_A, 16'h0000);
        step(C_READ, 9'h1F0, 16'h0000);
        checks++;
        if (read_data !== 16'h0000 || bad_access !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_read got rd=%h bad=%b want 0000 1", read_data, bad_access);
        end
        step(C_WRITE, SW_A, 16'h7777);
        for (int i = 0; i < 4; i++) step(C_NONE, 9'h000, 16'h0000);
        checks++;
        if (bad_access !== 1'b1 || led_out !== 8'hA5 || hex_value !== 16'hBEEF) begin
            errors++;
            $display("FAIL sticky_bad got bad=%b led=%h hex=%h want 1 A5 BEEF", bad_access, led_out, hex_value);
        end
    endtask

    task automatic test_timer();
        do_reset();
`ifdef MMIO_TIMER_EN
        step(C_WRITE, TMR_A, 16'hFFFE);
        for (int i = 0; i < 3; i++) step(C_NONE, 9'h000, 16'h0000);
        step(C_READ, TMR_A, 16'h0000);
        checks++;
        if (read_data !== 16'h0001) begin
            errors++;
            $display("FAIL timer_wrap got %h want 0001", read_data);
        end
        halt_drive = 1'b1;
        for (int i = 0; i < 10; i++) step(C_NONE, 9'h000, 16'h0000);
        step(C_READ, TMR_A, 16'h0000);
        checks++;
        if (read_data !== 16'h0002) begin
            errors++;
            $display("FAIL timer_halt got %h want 0002", read_data);
        end
        halt_drive = 1'b0;
        step(C_READ, TMR_A, 16'h0000);
        step(C_READ, TMR_A, 16'h0000);
`else
        step(C_WRITE, HEX_A, 16'h4321);
        step(C_READ, HEX_A, 16'h0000);
        step(C_READ, TMR_A, 16'h0000);
        checks++;
        if (read_data !== 16'h0000 || bad_access !== 1'b1) begin
            errors++;
            $display("FAIL timer_absent got rd=%h bad=%b want 0000 1", read_data, bad_access);
        end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) step(C_WRITE, 9'h020 + 9'(i), 16'(($urandom & 32'hFFFF)));
        step(C_WRITE, HEX_A, 16'h5A5A);
        step(C_READ, 9'h020, 16'h0000);
        step(C_READ, HEX_A, 16'h0000);
        step(C_READ, 9'h021, 16'h0000);
        step(C_READ, LED_A, 16'h0000);
        step(C_READ, 9'h022, 16'h0000);
        step(C_READ, 9'h023, 16'h0000);
        step(C_READ, SW_A, 16'h0000);
    endtask

    task automatic test_random();
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cmd = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0, 1, 2: addr = 9'($urandom_range(0, 15));
                3: addr = LED_A;
                4: addr = HEX_A;
                5: addr = SW_A;
                6: addr = TMR_A;
                default: addr = 9'($urandom_range(256, 511));
            endcase
            wd = 16'($urandom & 32'hFFFF);
            if ($urandom_range(0, 3) == 0) sw_drive = 8'($urandom & 32'hFF);
            halt_drive = ($urandom_range(0, 4) == 0);
            if (n == 200) do_reset();
            step(cmd, addr, wd);
        end
        halt_drive = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ram();
        test_io();
        test_switch();
        test_illegal();
        test_timer();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
